proc_ctrl_fsm: RTL and testbench

Parametrised control unit for the six-plus-instruction processor. It sequences Fetch/Decode/Execute and drives the PC, IR, data memory, register file, mux and ALU control lines from a 16-bit instruction. Compared with the fixed first-generation controller, it adds:
- a configurable multi-cycle data-memory load;
- a HALT that can be resumed with a handshake;
- optional JMP/JZ control flow.

---
 rtl/proc_ctrl_fsm.sv | 195 +++++++++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_fsm.sv
// Fetch/Decode/Execute controller: 1-cycle registered outputs (JZ PC_ld combinational from Ra_zero), LOAD waits LOAD_WAIT cycles, HALT stalls until Go.
// Define CTRL_JUMP_EN to decode opcodes 6/7 as JUMP/JZ; otherwise they act as NOOP and PC_ld/PC_ld_val stay 0.
module proc_ctrl_fsm #(
    parameter int LOAD_WAIT = 1,
    parameter int PC_W      = 8
) (
    input  logic            Clock,
    input  logic            reset,
    input  logic [15:0]     IR,
    input  logic            Go,
    input  logic            Ra_zero,
    output logic            PC_clr,
    output logic            PC_up,
    output logic            PC_ld,
    output logic [PC_W-1:0] PC_ld_val,
    output logic            IR_ld,
    output logic [7:0]      D_addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic            RF_W_en,
    output logic [2:0]      ALU_s0,
    output logic            Halted,
    output logic [3:0]      OutState,
    output logic [3:0]      OutNextState
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9,
        S_JUMP   = 4'd10,
        S_JZ     = 4'd11
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(LOAD_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_q;
    logic        pc_clr_q, pc_up_q, ir_ld_q, d_wr_q, rf_s_q, rf_w_en_q, halted_q;
    logic [7:0]  d_addr_q;
    logic [3:0]  rf_w_addr_q, rf_ra_addr_q, rf_rb_addr_q;
    logic [2:0]  alu_s0_q;

    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    4'd0:    state_d = S_NOOP;
                    4'd1:    state_d = S_STORE;
                    4'd2:    state_d = S_LOAD_A;
                    4'd3:    state_d = S_ADD;
                    4'd4:    state_d = S_SUB;
                    4'd5:    state_d = S_HALT;
`ifdef CTRL_JUMP_EN
                    4'd6:    state_d = S_JUMP;
                    4'd7:    state_d = S_JZ;
`endif
                    default: state_d = S_NOOP;
                endcase
            end
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
            S_LOAD_A: state_d = (wait_q == WAIT_LAST) ? S_LOAD_B : S_LOAD_A;
            S_HALT:   state_d = Go ? S_FETCH : S_HALT;
`ifdef CTRL_JUMP_EN
            S_JUMP, S_JZ: state_d = S_FETCH;
`endif
            default:  state_d = S_INIT;
        endcase
    end

`ifdef CTRL_JUMP_EN
    logic            pc_ld_q;
    logic [PC_W-1:0] pc_ld_val_q;
`endif

    // Outputs are decoded from the state being entered so they are valid for its whole cycle.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q      <= S_INIT;
            wait_q       <= '0;
            pc_clr_q     <= 1'b1;
            pc_up_q      <= 1'b0;
            ir_ld_q      <= 1'b0;
            d_addr_q     <= '0;
            d_wr_q       <= 1'b0;
            rf_s_q       <= 1'b0;
            rf_w_addr_q  <= '0;
            rf_ra_addr_q <= '0;
            rf_rb_addr_q <= '0;
            rf_w_en_q    <= 1'b0;
            alu_s0_q     <= '0;
            halted_q     <= 1'b0;
`ifdef CTRL_JUMP_EN
            pc_ld_q      <= 1'b0;
            pc_ld_val_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wait_q       <= (state_q == S_LOAD_A && state_d == S_LOAD_A) ? wait_q + 4'd1 : 4'd0;
            pc_clr_q     <= 1'b0;
            pc_up_q      <= 1'b0;
            ir_ld_q      <= 1'b0;
            d_addr_q     <= '0;
            d_wr_q       <= 1'b0;
            rf_s_q       <= 1'b0;
            rf_w_addr_q  <= '0;
            rf_ra_addr_q <= '0;
            rf_rb_addr_q <= '0;
            rf_w_en_q    <= 1'b0;
            alu_s0_q     <= '0;
            halted_q     <= 1'b0;
`ifdef CTRL_JUMP_EN
            pc_ld_q      <= 1'b0;
            pc_ld_val_q  <= '0;
`endif
            case (state_d)
                S_INIT:  pc_clr_q <= 1'b1;
                S_FETCH: begin
                    ir_ld_q <= 1'b1;
                    pc_up_q <= 1'b1;
                end
                S_LOAD_A, S_LOAD_B: begin
                    d_addr_q    <= IR[11:4];
                    rf_s_q      <= 1'b1;
                    rf_w_addr_q <= IR[3:0];
                    rf_w_en_q   <= (state_d == S_LOAD_B);
                end
                S_STORE: begin
                    d_addr_q     <= IR[7:0];
                    rf_ra_addr_q <= IR[11:8];
                    d_wr_q       <= 1'b1;
                end
                S_ADD, S_SUB: begin
                    rf_ra_addr_q <= IR[11:8];
                    rf_rb_addr_q <= IR[7:4];
                    rf_w_addr_q  <= IR[3:0];
                    rf_w_en_q    <= 1'b1;
                    alu_s0_q     <= (state_d == S_ADD) ? 3'd1 : 3'd2;
                end
                S_HALT:  halted_q <= 1'b1;
`ifdef CTRL_JUMP_EN
                S_JUMP: begin
                    pc_ld_q     <= 1'b1;
                    pc_ld_val_q <= IR[PC_W-1:0];
                end
                S_JZ: begin
                    rf_ra_addr_q <= IR[11:8];
                    pc_ld_val_q  <= PC_W'(IR[7:0]);
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef CTRL_JUMP_EN
    // Ra_zero comes straight from the RF read port in the JZ cycle, so this one output is Mealy.
    assign PC_ld     = pc_ld_q | ((state_q == S_JZ) & Ra_zero);
    assign PC_ld_val = pc_ld_val_q;
`else
    logic unused_ra_zero;
    assign unused_ra_zero = Ra_zero;
    assign PC_ld     = 1'b0;
    assign PC_ld_val = '0;
`endif

    assign PC_clr       = pc_clr_q;
    assign PC_up        = pc_up_q;
    assign IR_ld        = ir_ld_q;
    assign D_addr       = d_addr_q;
    assign D_wr         = d_wr_q;
    assign RF_s         = rf_s_q;
    assign RF_W_addr    = rf_w_addr_q;
    assign RF_Ra_addr   = rf_ra_addr_q;
    assign RF_Rb_addr   = rf_rb_addr_q;
    assign RF_W_en      = rf_w_en_q;
    assign ALU_s0       = alu_s0_q;
    assign Halted       = halted_q;
    assign OutState     = state_q;
    assign OutNextState = state_d;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: instruction table, hand-written reset/abort sequences and random instruction streams.
module tb_proc_ctrl_fsm;

    localparam int LW   = 3;
    localparam int PC_W = 8;
`ifdef CTRL_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic            Clock = 1'b0;
    logic            reset = 1'b0;
    logic [15:0]     IR = '0;
    logic            Go = 1'b0;
    logic            Ra_zero = 1'b0;
    logic            PC_clr, PC_up, PC_ld, IR_ld, D_wr, RF_s, RF_W_en, Halted;
    logic [PC_W-1:0] PC_ld_val;
    logic [7:0]      D_addr;
    logic [3:0]      RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState, OutNextState;
    logic [2:0]      ALU_s0;

    always #5 Clock = ~Clock;

    proc_ctrl_fsm #(.LOAD_WAIT(LW), .PC_W(PC_W)) dut (
        .Clock(Clock), .reset(reset), .IR(IR), .Go(Go), .Ra_zero(Ra_zero),
        .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld), .PC_ld_val(PC_ld_val),
        .IR_ld(IR_ld), .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
        .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .RF_W_en(RF_W_en), .ALU_s0(ALU_s0), .Halted(Halted),
        .OutState(OutState), .OutNextState(OutNextState)
    );

    typedef struct packed {
        logic            pc_clr;
        logic            pc_up;
        logic            pc_ld;
        logic [PC_W-1:0] pc_ld_val;
        logic            ir_ld;
        logic [7:0]      d_addr;
        logic            d_wr;
        logic            rf_s;
        logic [3:0]      w_addr;
        logic [3:0]      ra_addr;
        logic [3:0]      rb_addr;
        logic            w_en;
        logic [2:0]      alu;
        logic            halted;
    } outs_t;

    outs_t act;
    assign act = {PC_clr, PC_up, PC_ld, PC_ld_val, IR_ld, D_addr, D_wr, RF_s,
                  RF_W_addr, RF_Ra_addr, RF_Rb_addr, RF_W_en, ALU_s0, Halted};

    typedef struct {
        logic [15:0] ir;
        logic        rz;
        int          nhalt;
        logic [3:0]  exp_exec;
        int          exp_cycles;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    // Expected control lines while sitting in a given state.
    function automatic outs_t exp_out(input logic [3:0] st, input logic [15:0] ir, input logic rz);
        outs_t o;
        o = '0;
        case (st)
            4'd0: o.pc_clr = 1'b1;
            4'd1: begin o.ir_ld = 1'b1; o.pc_up = 1'b1; end
            4'd4, 4'd5: begin
                o.d_addr = ir[11:4]; o.rf_s = 1'b1; o.w_addr = ir[3:0];
                o.w_en = (st == 4'd5);
            end
            4'd6: begin o.d_addr = ir[7:0]; o.ra_addr = ir[11:8]; o.d_wr = 1'b1; end
            4'd7, 4'd8: begin
                o.ra_addr = ir[11:8]; o.rb_addr = ir[7:4]; o.w_addr = ir[3:0];
                o.w_en = 1'b1; o.alu = (st == 4'd7) ? 3'd1 : 3'd2;
            end
            4'd9: o.halted = 1'b1;
            4'd10: begin o.pc_ld = 1'b1; o.pc_ld_val = ir[7:0]; end
            4'd11: begin o.ra_addr = ir[11:8]; o.pc_ld_val = ir[7:0]; o.pc_ld = rz; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic [3:0] model_exec(input logic [3:0] op);
        logic [3:0] tbl [16];
        tbl = '{4'd3, 4'd6, 4'd4, 4'd7, 4'd8, 4'd9, 4'd3, 4'd3,
                4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
        if (JEN) begin
            tbl[6] = 4'd10;
            tbl[7] = 4'd11;
        end
        return tbl[op];
    endfunction

    function automatic int model_cycles(input logic [3:0] exec, input int nhalt);
        if (exec == 4'd4) return LW + 3;
        if (exec == 4'd9) return nhalt + 3;
        return 3;
    endfunction

    task automatic chk4(input string nm, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic chko(input string nm, input outs_t got, input outs_t want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Starts with the DUT in Fetch, ends with it back in Fetch.
    task automatic run_instr(input logic [15:0] ir, input logic rz, input int nhalt,
                             input logic [3:0] exec, input int cycles);
        logic [3:0] seq [$];
        seq = {};
        seq.push_back(4'd1);
        seq.push_back(4'd2);
        for (int k = 0; k < cycles - 2; k++) begin
            if (exec == 4'd4) seq.push_back((k == cycles - 3) ? 4'd5 : 4'd4);
            else              seq.push_back(exec);
        end
        seq.push_back(4'd1);
        for (int i = 0; i < seq.size() - 1; i++) begin
            IR      = ir;
            Ra_zero = (seq[i] == 4'd11) ? rz : 1'($urandom);
            Go      = (seq[i] == 4'd9) ? (i == seq.size() - 2) : 1'($urandom);
            #1;
            chk4($sformatf("state ir=%h c%0d", ir, i), OutState, seq[i]);
            chk4($sformatf("next ir=%h c%0d", ir, i), OutNextState, seq[i+1]);
            chko($sformatf("outs ir=%h c%0d", ir, i), act, exp_out(seq[i], ir, rz));
            step();
        end
        Go = 1'b0;
    endtask

    // Abort an instruction after `ncyc` cycles with reset, then return to Fetch.
    task automatic reset_mid(input logic [15:0] ir, input int ncyc);
        IR = ir;
        Go = 1'b0;
        repeat (ncyc) step();
        reset = 1'b0;
        step();
        #1;
        chk4($sformatf("abort state ir=%h", ir), OutState, 4'd0);
        chk4($sformatf("abort next ir=%h", ir), OutNextState, 4'd1);
        chko($sformatf("abort outs ir=%h", ir), act, exp_out(4'd0, ir, 1'b0));
        reset = 1'b1;
        step();
    endtask

    vec_t vecs [$];

    initial begin
        logic [3:0]  j6, j7;
        logic [15:0] rir;
        logic [3:0]  rex;
        int          rnh;

        j6 = JEN ? 4'd10 : 4'd3;
        j7 = JEN ? 4'd11 : 4'd3;
        vecs = '{
            '{16'h3124, 1'b0, 0, 4'd7, 3},
            '{16'h2A57, 1'b0, 0, 4'd4, 6},
            '{16'h5000, 1'b0, 5, 4'd9, 8},
            '{16'h5000, 1'b0, 0, 4'd9, 3},
            '{16'h1234, 1'b0, 0, 4'd6, 3},
            '{16'h4567, 1'b1, 0, 4'd8, 3},
            '{16'h0ABC, 1'b0, 0, 4'd3, 3},
            '{16'hF000, 1'b0, 0, 4'd3, 3},
            '{16'h8123, 1'b1, 0, 4'd3, 3},
            '{16'h6000, 1'b0, 0, j6,   3},
            '{16'h60C3, 1'b0, 0, j6,   3},
            '{16'h7210, 1'b1, 0, j7,   3},
            '{16'h7210, 1'b0, 0, j7,   3},
            '{16'h2001, 1'b1, 0, 4'd4, 6}
        };

        reset = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #1;
        chk4("reset state", OutState, 4'd0);
        chk4("reset next", OutNextState, 4'd1);
        chko("reset outs", act, exp_out(4'd0, IR, 1'b0));
        reset = 1'b1;
        step();

        foreach (vecs[v])
            run_instr(vecs[v].ir, vecs[v].rz, vecs[v].nhalt, vecs[v].exp_exec, vecs[v].exp_cycles);

        // Abort in the second LOAD_A cycle, then a full LOAD must still wait LW cycles.
        reset_mid(16'h2A57, 3);
        run_instr(16'h2A57, 1'b0, 0, 4'd4, LW + 3);
        reset_mid(16'h5000, 4);
        run_instr(16'h3124, 1'b0, 0, 4'd7, 3);

        for (int r = 0; r < 200; r++) begin
            rir = 16'($urandom);
            rnh = $urandom_range(0, 3);
            rex = model_exec(rir[15:12]);
            run_instr(rir, 1'($urandom), rnh, rex, model_cycles(rex, rnh));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
